// File: rtl/pump_ctrl.sv
// pump_ctrl
//   Protected pump motor driver. It takes the raw motor-on request from the
//   tank controller and adds a minimum on-time and a minimum off-time
//   (anti-short-cycle). It also detects dry-run and over-long-run faults.
//   A fault is latched and keeps the pump off until software acknowledges it.
//
// Ports
//   clk        : system clock, rising edge
//   rst        : asynchronous active-low reset
//   en         : pump subsystem enable
//   mon_req    : motor-on request, synchronous to clk
//   dry        : asynchronous dry-run sensor (1 = no water at inlet)
//   fault_clr  : fault acknowledge, only looked at while in FAULT
//   pump_on    : registered pump drive
//   fault      : latched fault flag
//   fault_code : 00 none, 01 dry-run, 10 timeout
//   state      : 00 IDLE, 01 RUN, 10 OFFWAIT, 11 FAULT
//   cnt        : run cycles in RUN, cool-down cycles in OFFWAIT, 0 otherwise
//
// Handshake: there is no valid/ready pair here. mon_req is a level request
// that is sampled on every rising edge. fault_clr is a level acknowledge,
// and it acts on the first rising edge on which it is high in FAULT.
module pump_ctrl #(
  parameter int MIN_ON  = 8,
  parameter int MIN_OFF = 8,
  parameter int MAX_RUN = 1000,
  parameter int DRY_LIM = 4,
  parameter int CW      = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          mon_req,
  input  logic          dry,
  input  logic          fault_clr,
  output logic          pump_on,
  output logic          fault,
  output logic [1:0]    fault_code,
  output logic [1:0]    state,
  output logic [CW-1:0] cnt
);

  // dry_cnt can reach DRY_LIM for one cycle, on the edge that leaves RUN.
  localparam int DW = $clog2(DRY_LIM + 1);

  localparam logic [CW-1:0] ON_LAST  = CW'(MIN_ON - 1);
  localparam logic [CW-1:0] OFF_LAST = CW'(MIN_OFF - 1);
  localparam logic [CW-1:0] RUN_LAST = CW'(MAX_RUN - 1);
  localparam logic [DW-1:0] DRY_LAST = DW'(DRY_LIM - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_OFF   = 2'b10,
    S_FAULT = 2'b11
  } state_t;

  state_t          cur_state;
  state_t          nxt_state;
  logic            dry_meta;
  logic            dry_s;
  logic [DW-1:0]   dry_cnt;
  logic [DW-1:0]   dry_cnt_d;
  logic [CW-1:0]   cnt_d;
  logic            pump_on_d;
  logic            fault_d;
  logic [1:0]      fault_code_d;
  logic            dry_trip;
  logic            run_trip;

  assign state = cur_state;

  // Fault triggers as seen in RUN. They are only acted on when en is high,
  // because a disable always wins and sends the block to OFFWAIT.
  assign dry_trip = dry_s && (dry_cnt == DRY_LAST);
  assign run_trip = (cnt == RUN_LAST);

  // Two-flop synchronizer for the asynchronous dry sensor.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dry_meta <= 1'b0;
      dry_s    <= 1'b0;
    end else begin
      dry_meta <= dry;
      dry_s    <= dry_meta;
    end
  end

  // State register, with all outputs registered next to it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_state  <= S_IDLE;
      pump_on    <= 1'b0;
      fault      <= 1'b0;
      fault_code <= 2'b00;
      cnt        <= '0;
      dry_cnt    <= '0;
    end else begin
      cur_state  <= nxt_state;
      pump_on    <= pump_on_d;
      fault      <= fault_d;
      fault_code <= fault_code_d;
      cnt        <= cnt_d;
      dry_cnt    <= dry_cnt_d;
    end
  end

  // Next-state logic. The order of the RUN branches sets the exit priority.
  always_comb begin
    nxt_state = cur_state;
    unique case (cur_state)
      S_IDLE: begin
        if (en && mon_req) nxt_state = S_RUN;
      end
      S_RUN: begin
        if (!en)                           nxt_state = S_OFF;
        else if (dry_trip)                 nxt_state = S_FAULT;
        else if (run_trip)                 nxt_state = S_FAULT;
        else if (!mon_req && cnt >= ON_LAST) nxt_state = S_OFF;
      end
      S_OFF: begin
        // en and mon_req are deliberately ignored during the cool-down.
        if (cnt == OFF_LAST) nxt_state = S_IDLE;
      end
      S_FAULT: begin
        if (fault_clr) nxt_state = S_OFF;
      end
      default: nxt_state = S_IDLE;
    endcase
  end

  // Output and datapath next values. These are derived from the transition.
  always_comb begin
    pump_on_d    = (nxt_state == S_RUN);
    fault_d      = (nxt_state == S_FAULT);
    fault_code_d = 2'b00;
    if (nxt_state == S_FAULT) begin
      if (cur_state == S_FAULT) fault_code_d = fault_code;
      else                      fault_code_d = dry_trip ? 2'b01 : 2'b10;
    end

    // The counter restarts from 0 on every state change and advances only
    // while the block stays in RUN or OFFWAIT. The exit compares stop it
    // well before it could wrap.
    cnt_d = '0;
    if ((nxt_state == cur_state) && (cur_state == S_RUN || cur_state == S_OFF))
      cnt_d = cnt + CW'(1);

    dry_cnt_d = '0;
    if (cur_state == S_RUN && dry_s) dry_cnt_d = dry_cnt + DW'(1);
  end

endmodule

// File: tb/tb_pump_ctrl.sv
// tb_pump_ctrl
//   Randomized and directed checks of pump_ctrl against a behavioural model.
//   Inputs are driven on the falling edge. The model advances on the rising
//   edge, and the DUT is compared against it 2 time units after each rising
//   edge.
module tb_pump_ctrl;

  localparam int MIN_ON  = 8;
  localparam int MIN_OFF = 8;
  localparam int MAX_RUN = 20;
  localparam int DRY_LIM = 4;
  localparam int CW      = 16;

  localparam int P_IDLE  = 0;
  localparam int P_RUN   = 1;
  localparam int P_OFF   = 2;
  localparam int P_FAULT = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  logic en;
  logic mon_req;
  logic dry;
  logic fault_clr;
  logic          pump_on;
  logic          fault;
  logic [1:0]    fault_code;
  logic [1:0]    state;
  logic [CW-1:0] cnt;

  always #5 clk = ~clk;

  pump_ctrl #(
    .MIN_ON (MIN_ON),
    .MIN_OFF(MIN_OFF),
    .MAX_RUN(MAX_RUN),
    .DRY_LIM(DRY_LIM),
    .CW     (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .mon_req   (mon_req),
    .dry       (dry),
    .fault_clr (fault_clr),
    .pump_on   (pump_on),
    .fault     (fault),
    .fault_code(fault_code),
    .state     (state),
    .cnt       (cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // phase: what the pump is doing; age: cycles spent in the current phase;
  // dry_hist: the last two raw dry samples (the synchronizer delay);
  // dry_run: how many consecutive RUN cycles have seen a synced dry.
  int m_phase = P_IDLE;
  int m_age   = 0;
  int m_code  = 0;
  int m_dry_run = 0;
  bit dry_hist[2] = '{1'b0, 1'b0};
  bit m_ds;
  int m_new_dry_run;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_phase = P_IDLE; m_age = 0; m_code = 0; m_dry_run = 0;
      dry_hist[0] = 1'b0; dry_hist[1] = 1'b0;
    end else begin
      m_ds = dry_hist[1];
      dry_hist[1] = dry_hist[0];
      dry_hist[0] = dry;
      m_new_dry_run = (m_phase == P_RUN && m_ds) ? m_dry_run + 1 : 0;
      case (m_phase)
        P_IDLE: if (en && mon_req) begin m_phase = P_RUN; m_age = 0; end
        P_RUN: begin
          if (!en) begin
            m_phase = P_OFF; m_age = 0;
          end else if (m_ds && m_dry_run + 1 >= DRY_LIM) begin
            m_phase = P_FAULT; m_age = 0; m_code = 1;
          end else if (m_age + 1 >= MAX_RUN) begin
            m_phase = P_FAULT; m_age = 0; m_code = 2;
          end else if (!mon_req && m_age + 1 >= MIN_ON) begin
            m_phase = P_OFF; m_age = 0;
          end else begin
            m_age++;
          end
        end
        P_OFF: begin
          if (m_age + 1 >= MIN_OFF) begin m_phase = P_IDLE; m_age = 0; end
          else m_age++;
        end
        default: if (fault_clr) begin m_phase = P_OFF; m_age = 0; m_code = 0; end
      endcase
      m_dry_run = m_new_dry_run;
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(posedge clk) begin
    #2;
    if (rst === 1'b1) begin
      check("state",      int'(state),      m_phase);
      check("pump_on",    int'(pump_on),    (m_phase == P_RUN) ? 1 : 0);
      check("fault",      int'(fault),      (m_phase == P_FAULT) ? 1 : 0);
      check("fault_code", int'(fault_code), m_code);
      check("cnt",        int'(cnt),        (m_phase == P_RUN || m_phase == P_OFF) ? m_age : 0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_idle(input string name);
    int s;
    s = int'(state);
    for (int i = 0; i < 200 && s != P_IDLE; i++) begin
      @(negedge clk);
      s = int'(state);
    end
    check(name, s, P_IDLE);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  int hi;
  int lo;
  int lat;
  int saw_fault;
  int dry_burst;

  initial begin
    rst = 1'b0; en = 1'b1; mon_req = 1'b1; dry = 1'b1; fault_clr = 1'b0;

    // Reset held with request and dry active.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_pump_on", int'(pump_on), 0);
    check("rst_fault", int'(fault), 0);
    check("rst_code", int'(fault_code), 0);
    check("rst_state", int'(state), 0);
    check("rst_cnt", int'(cnt), 0);
    dry = 1'b0; rst = 1'b1;
    @(negedge clk);
    check("rst_release_pump_on", int'(pump_on), 1);
    mon_req = 1'b0;
    wait_idle("rst_idle");

    // Minimum on-time: a 2-cycle request still gives 8 cycles of drive.
    @(negedge clk);
    mon_req = 1'b1; hi = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 1) mon_req = 1'b0;
      if (pump_on) hi++;
      else if (hi > 0) break;
    end
    check("min_on_len", hi, 8);
    check("min_on_offwait", int'(state), P_OFF);
    lo = 0;
    for (int i = 0; i < 40 && state == 2'b10; i++) begin
      lo++;
      @(negedge clk);
    end
    check("min_off_len", lo, 8);
    check("min_off_idle", int'(state), P_IDLE);

    // Short-cycle: a request that comes back straight after a run must wait.
    mon_req = 1'b1; hi = 0;
    for (int i = 0; i < 40 && hi < 10; i++) begin
      @(negedge clk);
      if (pump_on) hi++;
    end
    mon_req = 1'b0;
    @(negedge clk);
    mon_req = 1'b1; lo = 1;
    for (int i = 0; i < 40 && !pump_on; i++) begin
      @(negedge clk);
      if (!pump_on) lo++;
    end
    check("short_cycle_low", lo, MIN_OFF + 1);
    mon_req = 1'b0;
    wait_idle("short_idle");

    // Dry-run fault latency and acknowledge.
    @(negedge clk);
    mon_req = 1'b1;
    repeat (2) @(negedge clk);
    dry = 1'b1; lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (state == 2'b11) begin lat = i; break; end
    end
    check("dry_latency", lat, 6);
    check("dry_code", int'(fault_code), 1);
    check("dry_pump_off", int'(pump_on), 0);
    check("model_dry_code", m_code, 1);
    dry = 1'b0; mon_req = 1'b0; fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
    check("dry_clr_state", int'(state), P_OFF);
    check("dry_clr_fault", int'(fault), 0);
    check("dry_clr_code", int'(fault_code), 0);
    wait_idle("dry_idle");

    // Timeout after exactly MAX_RUN cycles, then fault holds with en low.
    @(negedge clk);
    mon_req = 1'b1; hi = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (pump_on) hi++;
      else if (hi > 0) break;
    end
    check("timeout_len", hi, MAX_RUN);
    check("timeout_state", int'(state), P_FAULT);
    check("timeout_code", int'(fault_code), 2);
    check("model_timeout_phase", m_phase, P_FAULT);
    en = 1'b0; mon_req = 1'b0;
    repeat (50) @(negedge clk);
    check("timeout_hold_state", int'(state), P_FAULT);
    check("timeout_hold_fault", int'(fault), 1);
    en = 1'b1; fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
    check("timeout_clr_state", int'(state), P_OFF);
    check("timeout_clr_fault", int'(fault), 0);
    wait_idle("timeout_idle");

    // Priority: a disable on the timeout edge wins, and no fault is latched.
    @(negedge clk);
    mon_req = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (state == 2'b01 && int'(cnt) == MAX_RUN - 1) begin en = 1'b0; break; end
    end
    @(negedge clk);
    check("prio_state", int'(state), P_OFF);
    check("prio_fault", int'(fault), 0);
    check("model_prio_phase", m_phase, P_OFF);
    en = 1'b1; mon_req = 1'b0;
    wait_idle("prio_idle");

    // A 3-cycle dry pulse is shorter than DRY_LIM and must not trip.
    @(negedge clk);
    mon_req = 1'b1;
    repeat (2) @(negedge clk);
    dry = 1'b1;
    repeat (3) @(negedge clk);
    dry = 1'b0; saw_fault = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (fault) saw_fault = 1;
    end
    check("dry_pulse_no_fault", saw_fault, 0);
    mon_req = 1'b0;
    wait_idle("pulse_idle");

    // Reset mid-run: the drive drops at once, and there is no cool-down after release.
    @(negedge clk);
    mon_req = 1'b1;
    repeat (4) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("midrst_pump_on", int'(pump_on), 0);
    check("midrst_state", int'(state), 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_restart", int'(pump_on), 1);
    mon_req = 1'b0;
    wait_idle("midrst_idle");

    // Randomized traffic, checked every cycle against the model.
    dry_burst = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      en = ($urandom_range(0, 99) < 95);
      if ($urandom_range(0, 9) == 0) mon_req = ~mon_req;
      if (dry_burst > 0) begin
        dry_burst--;
        dry = (dry_burst != 0);
      end else if ($urandom_range(0, 39) == 0) begin
        dry_burst = $urandom_range(1, 8);
        dry = 1'b1;
      end
      fault_clr = ($urandom_range(0, 14) == 0);
    end
    dry = 1'b0; fault_clr = 1'b0; mon_req = 1'b0;
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
